// File: rtl/dmem_align_ctrl.sv
// dmem_align_ctrl: aligns RV32I loads/stores onto a word-wide d-cache port and
// returns an extended, tagged completion to the LSQ.
`default_nettype none

module dmem_align_ctrl #(
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_is_store,
  output logic             resp_fault,
  output logic [31:0]      resp_rdata,
  output logic             data_read,
  output logic             data_write,
  output logic [3:0]       data_mbe,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  input  logic             data_resp,
  input  logic [31:0]      data_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic             op_store;
  logic [2:0]       op_funct3;
  logic [31:0]      op_addr;
  logic [31:0]      op_wdata;
  logic [TAG_W-1:0] op_tag;

  logic        accept;
  logic        req_fault;
  logic        active;
  logic [3:0]  store_mbe;
  logic [31:0] rd_shift;
  logic [31:0] ld_result;

  assign req_ready = (state == IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_fault = 1'b1;
    if (req_is_store) begin
      case (req_funct3)
        3'd0:    req_fault = 1'b0;
        3'd1:    req_fault = req_addr[0];
        3'd2:    req_fault = (req_addr[1:0] != 2'b00);
        default: req_fault = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'd0, 3'd4: req_fault = 1'b0;
        3'd1, 3'd5: req_fault = req_addr[0];
        3'd2:       req_fault = (req_addr[1:0] != 2'b00);
        default:    req_fault = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !req_fault) state_next = BUSY;
      BUSY: begin
        if (data_resp)  state_next = IDLE;
        else if (flush) state_next = DRAIN;
      end
      DRAIN:   if (data_resp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_store  <= 1'b0;
      op_funct3 <= 3'd0;
      op_addr   <= 32'd0;
      op_wdata  <= 32'd0;
      op_tag    <= '0;
    end else if (accept) begin
      op_store  <= req_is_store;
      op_funct3 <= req_funct3;
      op_addr   <= req_addr;
      op_wdata  <= req_wdata;
      op_tag    <= req_tag;
    end
  end

  // Cache-side outputs are forced to zero whenever no access is outstanding.
  assign active     = (state != IDLE);
  assign data_read  = active && !op_store;
  assign data_write = active && op_store;
  assign data_addr  = active ? {op_addr[31:2], 2'b00} : 32'd0;
  assign data_wdata = (active && op_store) ? (op_wdata << {op_addr[1:0], 3'b000}) : 32'd0;

  always_comb begin
    store_mbe = 4'b1111;
    case (op_funct3[1:0])
      2'd0:    store_mbe = 4'b0001 << op_addr[1:0];
      2'd1:    store_mbe = 4'b0011 << op_addr[1:0];
      default: store_mbe = 4'b1111;
    endcase
  end

  assign data_mbe = !active ? 4'b0000 : (op_store ? store_mbe : 4'b1111);

  assign rd_shift = data_rdata >> {op_addr[1:0], 3'b000};

  always_comb begin
    ld_result = rd_shift;
    case (op_funct3)
      3'd0:    ld_result = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd1:    ld_result = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'd4:    ld_result = {24'd0, rd_shift[7:0]};
      3'd5:    ld_result = {16'd0, rd_shift[15:0]};
      default: ld_result = rd_shift;
    endcase
  end

  // Completion register: faults report straight from the request, cache ops
  // one stage after data_resp; a flush kills whatever would appear next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid    <= 1'b0;
      resp_tag      <= '0;
      resp_is_store <= 1'b0;
      resp_fault    <= 1'b0;
      resp_rdata    <= 32'd0;
    end else begin
      resp_valid    <= 1'b0;
      resp_tag      <= '0;
      resp_is_store <= 1'b0;
      resp_fault    <= 1'b0;
      resp_rdata    <= 32'd0;
      if (accept && req_fault) begin
        resp_valid    <= 1'b1;
        resp_tag      <= req_tag;
        resp_is_store <= req_is_store;
        resp_fault    <= 1'b1;
      end else if ((state == BUSY) && data_resp && !flush) begin
        resp_valid    <= 1'b1;
        resp_tag      <= op_tag;
        resp_is_store <= op_store;
        resp_rdata    <= op_store ? 32'd0 : ld_result;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_align_ctrl.sv
// Bench for dmem_align_ctrl: directed vectors plus an arithmetic reference
// model checked against every output on every cycle.
`default_nettype none

module tb_dmem_align_ctrl;
  localparam int TAG_W = 3;

  logic             clk = 1'b0;
  logic             rst, flush, req_valid, req_is_store, data_resp;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr, req_wdata, data_rdata;
  logic [TAG_W-1:0] req_tag;
  logic             req_ready, resp_valid, resp_is_store, resp_fault;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      resp_rdata, data_addr, data_wdata;
  logic             data_read, data_write;
  logic [3:0]       data_mbe;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  dmem_align_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_is_store(resp_is_store),
    .resp_fault(resp_fault), .resp_rdata(resp_rdata),
    .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_resp(data_resp), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules, expressed as arithmetic on byte counts and offsets.
  function automatic bit fault_of(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int nb;
    if (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
    nb = 1 << f3[1:0];
    return (a % nb) != 0;
  endfunction

  function automatic logic [3:0] mbe_of(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int nb;
    int m;
    if (!st) return 4'hF;
    nb = 1 << f3[1:0];
    m  = ((1 << nb) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] load_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    longint v;
    int nb;
    nb = 1 << f3[1:0];
    v  = longint'(rd) >> (8 * (a % 4));
    v  = v % (longint'(1) << (8 * nb));
    if (f3 < 3'd4 && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  bit               m_busy, m_drain, m_st;
  logic [2:0]       m_f3;
  logic [31:0]      m_addr, m_wdata;
  logic [TAG_W-1:0] m_tag;
  bit               e_valid, e_st, e_fault;
  logic [TAG_W-1:0] e_tag;
  logic [31:0]      e_rdata;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_drain = 0;
      e_valid = 0; e_st = 0; e_fault = 0; e_tag = '0; e_rdata = 32'd0;
    end else begin
      e_valid = 0; e_st = 0; e_fault = 0; e_tag = '0; e_rdata = 32'd0;
      if (!m_busy) begin
        if (req_valid && !flush) begin
          if (fault_of(req_is_store, req_funct3, req_addr)) begin
            e_valid = 1; e_st = req_is_store; e_fault = 1; e_tag = req_tag;
          end else begin
            m_busy = 1; m_drain = 0; m_st = req_is_store; m_f3 = req_funct3;
            m_addr = req_addr; m_wdata = req_wdata; m_tag = req_tag;
          end
        end
      end else if (data_resp) begin
        if (!m_drain && !flush) begin
          e_valid = 1; e_st = m_st; e_tag = m_tag;
          e_rdata = m_st ? 32'd0 : load_of(m_f3, m_addr, data_rdata);
        end
        m_busy = 0; m_drain = 0;
      end else if (flush) begin
        m_drain = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] ew;
      ew = m_wdata << (8 * (m_addr % 4));
      chk("req_ready",     32'(req_ready),     32'(!m_busy && !flush));
      chk("data_read",     32'(data_read),     32'(m_busy && !m_st));
      chk("data_write",    32'(data_write),    32'(m_busy && m_st));
      chk("data_addr",     data_addr,          m_busy ? (m_addr - (m_addr % 4)) : 32'd0);
      chk("data_mbe",      32'(data_mbe),      m_busy ? 32'(mbe_of(m_st, m_f3, m_addr)) : 32'd0);
      chk("data_wdata",    data_wdata,         (m_busy && m_st) ? ew : 32'd0);
      chk("resp_valid",    32'(resp_valid),    32'(e_valid));
      chk("resp_tag",      32'(resp_tag),      32'(e_tag));
      chk("resp_is_store", 32'(resp_is_store), 32'(e_st));
      chk("resp_fault",    32'(resp_fault),    32'(e_fault));
      chk("resp_rdata",    resp_rdata,         e_rdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] w, input logic [TAG_W-1:0] t);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = w; req_tag = t;
    cyc();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_tag = '0; data_resp = 1'b0; data_rdata = 32'd0;
    cyc();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_mbe", 32'(data_mbe), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // lb at byte 3, cache answers on the second request cycle
    put_req(1'b0, 3'd0, 32'h0000_1003, 32'd0, 3'd1);
    data_rdata = 32'h80FF_FFFF;
    @(negedge clk);
    chk("lb_addr", data_addr, 32'h0000_1000);
    chk("lb_read", 32'(data_read), 32'd1);
    cyc();
    data_resp = 1'b1;
    @(negedge clk);
    chk("lb_read_held", 32'(data_read), 32'd1);
    cyc();
    data_resp = 1'b0;
    @(negedge clk);
    chk("lb_resp_valid", 32'(resp_valid), 32'd1);
    chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
    chk("lb_fault", 32'(resp_fault), 32'd0);
    cyc();

    // sh to the upper half, write held four cycles
    put_req(1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 3'd2);
    for (int i = 0; i < 4; i++) begin
      data_resp = (i == 3);
      @(negedge clk);
      chk("sh_write_held", 32'(data_write), 32'd1);
      chk("sh_mbe", 32'(data_mbe), 32'h0000_000C);
      chk("sh_wdata", data_wdata, 32'hBEEF_0000);
      cyc();
    end
    data_resp = 1'b0;
    @(negedge clk);
    chk("sh_resp_valid", 32'(resp_valid), 32'd1);
    chk("sh_resp_store", 32'(resp_is_store), 32'd1);
    cyc();

    // misaligned lw faults without touching the cache
    put_req(1'b0, 3'd2, 32'h0000_3001, 32'd0, 3'd3);
    @(negedge clk);
    chk("lw_fault_valid", 32'(resp_valid), 32'd1);
    chk("lw_fault_flag", 32'(resp_fault), 32'd1);
    chk("lw_fault_rdata", resp_rdata, 32'd0);
    chk("lw_fault_noread", 32'(data_read), 32'd0);
    cyc();

    // lhu flushed while busy; response discarded after drain
    put_req(1'b0, 3'd5, 32'h0000_4002, 32'd0, 3'd4);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 32'(req_ready), 32'd0);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("drain_ready", 32'(req_ready), 32'd0);
    chk("drain_read", 32'(data_read), 32'd1);
    cyc();
    data_resp = 1'b1;
    cyc();
    data_resp = 1'b0;
    @(negedge clk);
    chk("drain_no_resp", 32'(resp_valid), 32'd0);
    chk("drain_exit_ready", 32'(req_ready), 32'd1);
    cyc();

    // back-to-back lbu then sw, cache answers immediately
    put_req(1'b0, 3'd4, 32'h0000_0010, 32'd0, 3'd5);
    data_rdata = 32'h1122_3344;
    data_resp = 1'b1;
    cyc();
    data_resp = 1'b0;
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h0000_0014; req_wdata = 32'hCAFE_F00D; req_tag = 3'd6;
    @(negedge clk);
    chk("b2b_lbu_valid", 32'(resp_valid), 32'd1);
    chk("b2b_lbu_tag", 32'(resp_tag), 32'd5);
    chk("b2b_lbu_rdata", resp_rdata, 32'h0000_0044);
    cyc();
    req_valid = 1'b0;
    data_resp = 1'b1;
    @(negedge clk);
    chk("b2b_sw_wdata", data_wdata, 32'hCAFE_F00D);
    cyc();
    data_resp = 1'b0;
    @(negedge clk);
    chk("b2b_sw_valid", 32'(resp_valid), 32'd1);
    chk("b2b_sw_tag", 32'(resp_tag), 32'd6);
    cyc();

    // reset while busy with a pending cache answer
    put_req(1'b0, 3'd2, 32'h0000_0020, 32'd0, 3'd7);
    data_resp = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    data_resp = 1'b0;
    @(negedge clk);
    chk("rst_read", 32'(data_read), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    cyc();

    // sweep every funct3 and offset for loads and stores
    for (int k = 0; k < 64; k++) begin
      put_req(k[5], k[4:2], 32'h0000_0100 + 32'(k * 16) + 32'(k[1:0]), $urandom, k[2:0]);
      data_rdata = $urandom;
      for (int w = 0; w < k % 3; w++) cyc();
      data_resp = 1'b1;
      cyc();
      data_resp = 1'b0;
      cyc();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
